mem_lsu: RTL and testbench

Pipelined load/store stage for the RV32 core, sitting between EX and WB in place of the pass-through memory stage. Accepts one instruction per handshake, drives a req/ack data bus with wait states, generates byte enables for SB/SH/SW, aligns and sign/zero-extends LB/LH/LW/LBU/LHU data, and reports misalignment, bus error and bus timeout as a single-cycle exception to WB. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store stage between EX and WB: req/ack data bus with wait states, byte enables,
// load alignment/extension and a one-cycle exception pulse. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [31:0]           instc_i,
  input  logic                  mem_rena_i,
  input  logic                  mem_wena_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic                  reg_wena_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [31:0]           bus_rdata_i,
  output logic                  wb_valid_o,
  output logic [31:0]           instc_o,
  output logic                  reg_wena_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [31:0]           reg_wdata_o,
  output logic                  exc_o,
  output logic [1:0]            exc_cause_o,
  output logic [ADDR_W-1:0]     exc_addr_o,
  output logic                  dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  localparam int CNT_W   = $clog2(TIMEOUT_CYC + 2);
  localparam int TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  localparam logic [1:0] CAUSE_MISAL   = 2'd0;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_f3;
  logic [1:0]              r_lo;
  logic                    r_is_load;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [31:0]             r_instc;
  logic [ADDR_W-1:0]       r_maddr;

  logic [2:0]  w_f3;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_ld_ok;
  logic        w_st_ok;
  logic        w_illegal;
  logic        w_trap_mis;
  logic [1:0]  w_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_timeout;

  assign w_f3     = instc_i[14:12];
  assign w_accept = ex_valid_i & ex_ready_o;
  assign w_is_mem = mem_rena_i | mem_wena_i;
  assign w_ld_ok  = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
  assign w_st_ok  = (w_f3[2] == 1'b0) && (w_f3[1:0] != 2'b11);
  assign w_illegal = (mem_rena_i & mem_wena_i) |
                     (mem_rena_i & ~w_ld_ok) |
                     (mem_wena_i & ~w_st_ok);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap_mis = ((w_f3[1:0] == 2'b01) && mem_addr_i[0]) ||
                      ((w_f3[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));
`else
  assign w_trap_mis = 1'b0;
`endif

  // Low address bits after alignment: offending bits are cleared for half/word accesses.
  always_comb begin
    w_lo    = mem_addr_i[1:0];
    w_be    = 4'b1111;
    w_wdata = mem_wdata_i;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        w_lo    = {mem_addr_i[1], 1'b0};
        w_be    = 4'b0011 << w_lo;
        w_wdata = {2{mem_wdata_i[15:0]}};
      end
      default: w_lo = 2'b00;
    endcase
  end

  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TO_LAST));
  assign dbg_state_o = r_state;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_lo        <= '0;
      r_is_load   <= 1'b0;
      r_rd        <= '0;
      r_instc     <= '0;
      r_maddr     <= '0;
      ex_ready_o  <= 1'b1;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      wb_valid_o  <= 1'b0;
      instc_o     <= '0;
      reg_wena_o  <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      exc_o       <= 1'b0;
      exc_cause_o <= '0;
      exc_addr_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      exc_o      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              wb_valid_o  <= 1'b1;
              instc_o     <= instc_i;
              reg_wena_o  <= reg_wena_i;
              reg_waddr_o <= reg_waddr_i;
              reg_wdata_o <= reg_wdata_i;
            end else if (w_illegal || w_trap_mis) begin
              wb_valid_o  <= 1'b1;
              exc_o       <= 1'b1;
              exc_cause_o <= w_illegal ? CAUSE_ILLEGAL : CAUSE_MISAL;
              exc_addr_o  <= mem_addr_i;
              instc_o     <= instc_i;
              reg_wena_o  <= 1'b0;
              reg_waddr_o <= reg_waddr_i;
            end else begin
              r_state     <= S_BUS;
              ex_ready_o  <= 1'b0;
              r_cnt       <= '0;
              r_f3        <= w_f3;
              r_lo        <= w_lo;
              r_is_load   <= mem_rena_i;
              r_rd        <= reg_waddr_i;
              r_instc     <= instc_i;
              r_maddr     <= mem_addr_i;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_wena_i;
              bus_addr_o  <= mem_addr_i & WORD_MASK;
              bus_be_o    <= w_be;
              bus_wdata_o <= w_wdata;
            end
          end
        end
        S_BUS: begin
          // Error wins over ack; ack in the timeout cycle still completes normally.
          if (bus_err_i || bus_ack_i || w_timeout) begin
            r_state     <= S_IDLE;
            ex_ready_o  <= 1'b1;
            bus_req_o   <= 1'b0;
            wb_valid_o  <= 1'b1;
            instc_o     <= r_instc;
            reg_waddr_o <= r_rd;
            if (bus_err_i) begin
              exc_o       <= 1'b1;
              exc_cause_o <= CAUSE_BUSERR;
              exc_addr_o  <= r_maddr;
              reg_wena_o  <= 1'b0;
            end else if (bus_ack_i) begin
              reg_wena_o <= r_is_load;
              if (r_is_load) begin
                reg_wdata_o <= fmt_load(r_f3, r_lo, bus_rdata_i);
              end
            end else begin
              exc_o       <= 1'b1;
              exc_cause_o <= CAUSE_TIMEOUT;
              exc_addr_o  <= r_maddr;
              reg_wena_o  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads/stores with wait states, traps,
// bus error, timeout and asynchronous reset during a bus transaction.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] instc_i = '0;
  logic        mem_rena_i = 1'b0;
  logic        mem_wena_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        reg_wena_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        wb_valid_o;
  logic [31:0] instc_o;
  logic        reg_wena_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        exc_o;
  logic [1:0]  exc_cause_o;
  logic [31:0] exc_addr_o;
  logic        dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [31:0] exp_q[$];

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .instc_i(instc_i),
    .mem_rena_i(mem_rena_i), .mem_wena_i(mem_wena_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .reg_wena_i(reg_wena_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .wb_valid_o(wb_valid_o), .instc_o(instc_o), .reg_wena_o(reg_wena_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction; returns one time unit after the accepting edge.
  task automatic issue(input logic rena, input logic wena, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rwe, input logic [4:0] rd, input logic [31:0] rwd);
    @(negedge clk);
    ex_valid_i  = 1'b1;
    mem_rena_i  = rena;
    mem_wena_i  = wena;
    instc_i     = 32'h0000_0003 | ({29'd0, f3} << 12);
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    reg_wena_i  = rwe;
    reg_waddr_i = rd;
    reg_wdata_i = rwd;
    acc_cyc     = cyc;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    mem_rena_i = 1'b0;
    mem_wena_i = 1'b0;
    reg_wena_i = 1'b0;
  endtask

  // Hold off for 'waits' cycles checking the request stays up, then answer once.
  task automatic run_bus(input int waits, input logic ack, input logic err,
                         input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) begin
      check("req_held", bus_req_o, 1);
      check("ready_low", ex_ready_o, 0);
      @(posedge clk); #1;
    end
    if (ack || err) begin
      check("req_held", bus_req_o, 1);
      bus_ack_i   = ack;
      bus_err_i   = err;
      bus_rdata_i = rdata;
      @(posedge clk); #1;
      bus_ack_i   = 1'b0;
      bus_err_i   = 1'b0;
      bus_rdata_i = '0;
    end
  endtask

  task automatic check_wb(input string tag, input int exp_lat);
    check({tag, "_wb_valid"}, wb_valid_o, 1);
    check({tag, "_latency"}, cyc - acc_cyc, exp_lat);
    check({tag, "_req_drop"}, bus_req_o, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    issue(1'b1, 1'b0, f3, addr, 32'd0, 1'b1, 5'd7, 32'd0);
    check({tag, "_state"}, dbg_state_o, 1);
    check({tag, "_addr"}, bus_addr_o, exp_addr);
    check({tag, "_we"}, bus_we_o, 0);
    run_bus(waits, 1'b1, 1'b0, rdata);
    check_wb(tag, waits + 2);
    check({tag, "_exc"}, exc_o, 0);
    check({tag, "_wena"}, reg_wena_o, 1);
    check({tag, "_waddr"}, reg_waddr_o, 7);
    check({tag, "_data"}, reg_wdata_o, exp_q.pop_front());
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    issue(1'b0, 1'b1, f3, addr, wdata, 1'b0, 5'd0, 32'd0);
    check({tag, "_addr"}, bus_addr_o, exp_addr);
    check({tag, "_be"}, bus_be_o, exp_be);
    check({tag, "_wdata"}, bus_wdata_o, exp_wdata);
    check({tag, "_we"}, bus_we_o, 1);
    run_bus(0, 1'b1, 1'b0, 32'd0);
    check_wb(tag, 2);
    check({tag, "_wena"}, reg_wena_o, 0);
    check({tag, "_exc"}, exc_o, 0);
  endtask

  task automatic do_illegal(input string tag, input logic rena, input logic wena,
                            input logic [2:0] f3, input logic [31:0] addr);
    issue(rena, wena, f3, addr, 32'd0, 1'b1, 5'd9, 32'd0);
    check_wb(tag, 1);
    check({tag, "_exc"}, exc_o, 1);
    check({tag, "_cause"}, exc_cause_o, 3);
    check({tag, "_wena"}, reg_wena_o, 0);
  endtask

  initial begin
    logic saw_wb;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ex_ready_o, 1);
    check("rst_req", bus_req_o, 0);
    check("rst_wb", wb_valid_o, 0);
    check("rst_exc", exc_o, 0);
    check("rst_rdata", reg_wdata_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Pass-through
    issue(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    check_wb("pass", 1);
    check("pass_wena", reg_wena_o, 1);
    check("pass_waddr", reg_waddr_o, 5);
    check("pass_wdata", reg_wdata_o, 32'h0000_1234);
    check("pass_exc", exc_o, 0);
    check("pass_instc", instc_o, 32'h0000_0003);
    @(posedge clk); #1;
    check("pass_pulse", wb_valid_o, 0);
    check("pass_hold", reg_wdata_o, 32'h0000_1234);

    // Loads
    do_load("lb",  3'b000, 32'h0000_0103, 2, 32'h80FF_0011, 32'h0000_0100, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 2, 32'h80FF_0011, 32'h0000_0100, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0102, 0, 32'h80FF_0011, 32'h0000_0100, 32'hFFFF_80FF);
    do_load("lhu", 3'b101, 32'h0000_0100, 1, 32'h80FF_0011, 32'h0000_0100, 32'h0000_0011);
    do_load("lw",  3'b010, 32'h0000_0104, 0, 32'h80FF_0011, 32'h0000_0104, 32'h80FF_0011);

    // Stores
    do_store("sh", 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    do_store("sb", 3'b000, 32'h0000_0201, 32'h1234_565A, 32'h0000_0200, 4'b0010, 32'h5A5A_5A5A);
    do_store("sw", 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0000_0204, 4'b1111, 32'hDEAD_BEEF);

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 1'b1, 5'd3, 32'd0);
    check_wb("mis", 1);
    check("mis_exc", exc_o, 1);
    check("mis_cause", exc_cause_o, 0);
    check("mis_addr", exc_addr_o, 32'h0000_0301);
    check("mis_wena", reg_wena_o, 0);
`else
    do_load("mis", 3'b010, 32'h0000_0301, 0, 32'hCAFE_F00D, 32'h0000_0300, 32'hCAFE_F00D);
    do_store("mis_sh", 3'b001, 32'h0000_0203, 32'h0000_1357, 32'h0000_0200, 4'b1100, 32'h1357_1357);
`endif

    // Timeout: request stays up for 8 cycles
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 1'b1, 5'd4, 32'd0);
    run_bus(8, 1'b0, 1'b0, 32'd0);
    check_wb("tmo", 9);
    check("tmo_exc", exc_o, 1);
    check("tmo_cause", exc_cause_o, 2);
    check("tmo_addr", exc_addr_o, 32'h0000_0400);
    check("tmo_wena", reg_wena_o, 0);

    // Error and ack together
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 1'b1, 5'd6, 32'd0);
    run_bus(1, 1'b1, 1'b1, 32'h1111_2222);
    check_wb("err", 3);
    check("err_exc", exc_o, 1);
    check("err_cause", exc_cause_o, 1);
    check("err_addr", exc_addr_o, 32'h0000_0500);
    check("err_wena", reg_wena_o, 0);
    @(posedge clk); #1;
    check("err_pulse", exc_o, 0);

    // Illegal encodings
    do_illegal("ill_rw", 1'b1, 1'b1, 3'b010, 32'h0000_0600);
    do_illegal("ill_ld", 1'b1, 1'b0, 3'b011, 32'h0000_0600);
    do_illegal("ill_st", 1'b0, 1'b1, 3'b100, 32'h0000_0600);

    // Reset while a transaction is in flight
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'd0, 1'b1, 5'd8, 32'd0);
    check("rstbus_req_before", bus_req_o, 1);
    #2;
    arst_n = 1'b0;
    #1;
    check("rstbus_req", bus_req_o, 0);
    check("rstbus_ready", ex_ready_o, 1);
    @(negedge clk);
    arst_n = 1'b1;
    saw_wb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (wb_valid_o) saw_wb = 1'b1;
    end
    check("rstbus_no_wb", saw_wb, 0);
    check("rstbus_ready_after", ex_ready_o, 1);
    check("rstbus_state", dbg_state_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
